stack_engine: RTL and testbench

- Initiator side of the register file's stack-pointer interface: sequences PUSH/POP/CALL/RET against data memory.
- Consumes sp_value (R3) and drives the stack_push/stack_pop pulses that move it.
- Sits between the control unit (op handshake), data memory (sync RAM, 1-cycle read latency), the register-file write port and the PC load path.
- Owns no SP copy; R3 is the only stack pointer.

---
 rtl/stack_pkg.sv | 33 +++
 rtl/stack_guard.sv | 24 ++
 rtl/stack_engine.sv | 153 +++++++++++++++
 tb/tb_stack_engine.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared stack definitions: op codes, engine state encoding and default stack bounds.
// Also imported by the register file and the control unit.
package stack_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned OP_W   = 2;
    localparam int unsigned REG_W  = 2;

    localparam logic [7:0] STACK_TOP_DEF   = 8'hFF;
    localparam logic [7:0] STACK_LIMIT_DEF = 8'hC0;

    typedef enum logic [OP_W-1:0] {
        OP_PUSH = 2'b00,
        OP_POP  = 2'b01,
        OP_CALL = 2'b10,
        OP_RET  = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WRITE   = 3'd1,
        ST_RD_REQ  = 3'd2,
        ST_RD_WAIT = 3'd3,
        ST_FIN     = 3'd4,
        ST_ERR     = 3'd5
    } state_e;

    // PUSH and CALL store to the stack; POP and RET load from it.
    function automatic logic is_write_op(input op_e op);
        return (op == OP_PUSH) || (op == OP_CALL);
    endfunction

endpackage

// File: rtl/stack_guard.sv
// Combinational stack bounds check.
// Flags overflow for stores below the limit and underflow for loads from an empty stack.
module stack_guard
    import stack_pkg::*;
#(
    parameter int unsigned        DATA_W      = 8,
    parameter logic [DATA_W-1:0]  STACK_TOP   = DATA_W'(STACK_TOP_DEF),
    parameter logic [DATA_W-1:0]  STACK_LIMIT = DATA_W'(STACK_LIMIT_DEF)
) (
    input  logic [OP_W-1:0]   op_code,
    input  logic [DATA_W-1:0] sp_value,
    output logic              ovf,
    output logic              udf
);

    logic wr_op;

    always_comb begin
        wr_op = is_write_op(op_e'(op_code));
        ovf   = wr_op && (sp_value < STACK_LIMIT);
        udf   = !wr_op && (sp_value == STACK_TOP);
    end

endmodule

// File: rtl/stack_engine.sv
// PUSH/POP/CALL/RET sequencer against a 1-cycle-latency sync RAM.
// R3 (sp_value) is the only stack pointer; this block only pulses it up or down.
module stack_engine
    import stack_pkg::*;
#(
    parameter int unsigned        DATA_W      = 8,
    parameter logic [DATA_W-1:0]  STACK_TOP   = DATA_W'(STACK_TOP_DEF),
    parameter logic [DATA_W-1:0]  STACK_LIMIT = DATA_W'(STACK_LIMIT_DEF)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              op_valid,
    output logic              op_ready,
    input  logic [OP_W-1:0]   op_code,
    input  logic [DATA_W-1:0] op_data,
    input  logic [DATA_W-1:0] op_target,
    input  logic [REG_W-1:0]  op_dest,
    input  logic [DATA_W-1:0] sp_value,
    output logic              stack_push,
    output logic              stack_pop,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              wb_en,
    output logic [REG_W-1:0]  wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              pc_load,
    output logic [DATA_W-1:0] pc_out,
    output logic              done,
    output logic              err_ovf,
    output logic              err_udf
);

    state_e             state_q, state_d;
    op_e                op_q;
    logic [DATA_W-1:0]  data_q;
    logic [DATA_W-1:0]  target_q;
    logic [DATA_W-1:0]  sp_snap_q;
    logic [REG_W-1:0]   dest_q;
    logic               accept;
    logic               ovf, udf;

    stack_guard #(
        .DATA_W      (DATA_W),
        .STACK_TOP   (STACK_TOP),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_guard (
        .op_code  (op_code),
        .sp_value (sp_value),
        .ovf      (ovf),
        .udf      (udf)
    );

    assign accept = op_valid && (state_q == ST_IDLE);

    // State register plus the operand snapshot taken at the handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_PUSH;
            data_q    <= '0;
            target_q  <= '0;
            sp_snap_q <= '0;
            dest_q    <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q      <= op_e'(op_code);
                data_q    <= op_data;
                target_q  <= op_target;
                sp_snap_q <= sp_value;
                dest_q    <= op_dest;
            end
        end
    end

    // Next state and state-decoded outputs; read data passes straight through in RD_WAIT.
    always_comb begin
        state_d    = state_q;
        op_ready   = 1'b0;
        stack_push = 1'b0;
        stack_pop  = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        wb_en      = 1'b0;
        wb_addr    = '0;
        wb_data    = '0;
        pc_load    = 1'b0;
        pc_out     = '0;
        done       = 1'b0;
        err_ovf    = 1'b0;
        err_udf    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    if (ovf || udf)
                        state_d = ST_ERR;
                    else if (is_write_op(op_e'(op_code)))
                        state_d = ST_WRITE;
                    else
                        state_d = ST_RD_REQ;
                end
            end
            ST_WRITE: begin
                mem_we     = 1'b1;
                mem_addr   = sp_snap_q;
                mem_wdata  = data_q;
                stack_push = 1'b1;
                state_d    = ST_FIN;
            end
            ST_FIN: begin
                done = 1'b1;
                if (op_q == OP_CALL) begin
                    pc_load = 1'b1;
                    pc_out  = target_q;
                end
                state_d = ST_IDLE;
            end
            ST_RD_REQ: begin
                mem_re    = 1'b1;
                mem_addr  = sp_snap_q + DATA_W'(1);
                stack_pop = 1'b1;
                state_d   = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                done = 1'b1;
                if (op_q == OP_POP) begin
                    wb_en   = 1'b1;
                    wb_addr = dest_q;
                    wb_data = mem_rdata;
                end else begin
                    pc_load = 1'b1;
                    pc_out  = mem_rdata;
                end
                state_d = ST_IDLE;
            end
            ST_ERR: begin
                done    = 1'b1;
                err_ovf = is_write_op(op_q);
                err_udf = !is_write_op(op_q);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_stack_engine.sv
// Self-checking bench for stack_engine with an R3 model and a sync RAM model.
module tb_stack_engine;
    import stack_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       op_valid;
    logic       op_ready;
    logic [1:0] op_code;
    logic [7:0] op_data, op_target;
    logic [1:0] op_dest;
    logic [7:0] sp;
    logic       stack_push, stack_pop;
    logic [7:0] mem_addr, mem_wdata;
    logic       mem_we, mem_re;
    logic [7:0] mem_rdata = 8'h00;
    logic       wb_en;
    logic [1:0] wb_addr;
    logic [7:0] wb_data;
    logic       pc_load;
    logic [7:0] pc_out;
    logic       done, err_ovf, err_udf;

    logic       sp_set = 1'b0;
    logic [7:0] sp_set_val = 8'hFF;
    logic [7:0] mem [256];
    int         cyc = 0;
    bit         mon_en = 1'b0;
    int         checks = 0;
    int         failures = 0;

    stack_engine dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .op_code(op_code), .op_data(op_data), .op_target(op_target), .op_dest(op_dest),
        .sp_value(sp), .stack_push(stack_push), .stack_pop(stack_pop),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
        .pc_load(pc_load), .pc_out(pc_out), .done(done), .err_ovf(err_ovf), .err_udf(err_udf)
    );

    always #5 clk = ~clk;

    // R3 model and sync RAM; the register file is not reset by the engine's reset.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (sp_set)          sp <= sp_set_val;
        else if (stack_push) sp <= sp - 8'd1;
        else if (stack_pop)  sp <= sp + 8'd1;
        if (mem_we) mem[mem_addr] <= mem_wdata;
        if (mem_re) mem_rdata <= mem[mem_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    typedef struct {
        int         due;
        logic       we;
        logic [7:0] addr;
        logic [7:0] wdata;
    } mexp_t;

    typedef struct {
        int         due;
        logic       wb_en;
        logic [1:0] wb_addr;
        logic [7:0] wb_data;
        logic       pc_load;
        logic [7:0] pc_out;
        logic       ovf;
        logic       udf;
    } dexp_t;

    mexp_t mq[$];
    dexp_t dq[$];

    // Scoreboard monitor: every memory access and every done pulse must match a queued expectation.
    always @(posedge clk) begin
        #1;
        if (mon_en) begin
            chk("push_pop_exclusive", 32'(stack_push && stack_pop), 32'(0));
            if (mem_we || mem_re) begin
                if (mq.size() == 0) begin
                    chk("unexpected_mem_access", 32'(1), 32'(0));
                end else begin
                    mexp_t m;
                    m = mq.pop_front();
                    chk("mem_cycle", 32'(cyc), 32'(m.due));
                    chk("mem_we", 32'(mem_we), 32'(m.we));
                    chk("mem_re", 32'(mem_re), 32'(!m.we));
                    chk("mem_addr", 32'(mem_addr), 32'(m.addr));
                    if (m.we) chk("mem_wdata", 32'(mem_wdata), 32'(m.wdata));
                    chk("stack_push", 32'(stack_push), 32'(m.we));
                    chk("stack_pop", 32'(stack_pop), 32'(!m.we));
                end
            end
            if (done) begin
                if (dq.size() == 0) begin
                    chk("unexpected_done", 32'(1), 32'(0));
                end else begin
                    dexp_t d;
                    d = dq.pop_front();
                    chk("done_cycle", 32'(cyc), 32'(d.due));
                    chk("wb_en", 32'(wb_en), 32'(d.wb_en));
                    if (d.wb_en) begin
                        chk("wb_addr", 32'(wb_addr), 32'(d.wb_addr));
                        chk("wb_data", 32'(wb_data), 32'(d.wb_data));
                    end
                    chk("pc_load", 32'(pc_load), 32'(d.pc_load));
                    if (d.pc_load) chk("pc_out", 32'(pc_out), 32'(d.pc_out));
                    chk("err_ovf", 32'(err_ovf), 32'(d.ovf));
                    chk("err_udf", 32'(err_udf), 32'(d.udf));
                end
            end
        end
    end

    typedef struct {
        string      name;
        logic [1:0] op;
        logic [7:0] data;
        logic [7:0] target;
        logic [1:0] dest;
        bit         set_sp;
        logic [7:0] sp_init;
        logic [7:0] addr;
        logic [7:0] val;
        logic       ovf;
        logic       udf;
        logic [7:0] sp_after;
    } vec_t;

    function automatic vec_t mk(input string name, input logic [1:0] op, input logic [7:0] data,
                                input logic [7:0] target, input logic [1:0] dest, input bit set_sp,
                                input logic [7:0] sp_init, input logic [7:0] addr, input logic [7:0] val,
                                input logic ovf, input logic udf, input logic [7:0] sp_after);
        vec_t v;
        v.name = name; v.op = op; v.data = data; v.target = target; v.dest = dest;
        v.set_sp = set_sp; v.sp_init = sp_init; v.addr = addr; v.val = val;
        v.ovf = ovf; v.udf = udf; v.sp_after = sp_after;
        return v;
    endfunction

    task automatic load_sp(input logic [7:0] v);
        sp_set_val = v;
        sp_set = 1'b1;
        @(posedge clk); #1;
        sp_set = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!op_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!op_ready) chk("ready_timeout", 32'(0), 32'(1));
    endtask

    task automatic run_vec(input vec_t v);
        mexp_t m;
        dexp_t d;
        int    c0;
        if (v.set_sp) load_sp(v.sp_init);
        wait_ready();
        c0 = cyc;
        d.wb_en = 1'b0; d.wb_addr = v.dest; d.wb_data = v.val;
        d.pc_load = 1'b0; d.pc_out = 8'h00; d.ovf = v.ovf; d.udf = v.udf;
        if (v.ovf || v.udf) begin
            d.due = c0 + 1;
        end else begin
            m.due = c0 + 1; m.we = !v.op[0]; m.addr = v.addr; m.wdata = v.val;
            mq.push_back(m);
            d.due = c0 + 2;
            case (v.op)
                2'b01: d.wb_en = 1'b1;
                2'b10: begin d.pc_load = 1'b1; d.pc_out = v.target; end
                2'b11: begin d.pc_load = 1'b1; d.pc_out = v.val; end
                default: ;
            endcase
        end
        dq.push_back(d);
        op_code = v.op; op_data = v.data; op_target = v.target; op_dest = v.dest;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk({v.name, "_sp_after"}, 32'(sp), 32'(v.sp_after));
        chk({v.name, "_queues_drained"}, 32'(mq.size() + dq.size()), 32'(0));
        mq.delete();
        dq.delete();
    endtask

    vec_t vecs[$];

    initial begin
        vecs.push_back(mk("push_a5",    2'b00, 8'hA5, 8'h00, 2'd0, 1, 8'hFF, 8'hFF, 8'hA5, 0, 0, 8'hFE));
        vecs.push_back(mk("pop_r1",     2'b01, 8'h00, 8'h00, 2'd1, 0, 8'h00, 8'hFF, 8'hA5, 0, 0, 8'hFF));
        vecs.push_back(mk("call_40",    2'b10, 8'h12, 8'h40, 2'd0, 0, 8'h00, 8'hFF, 8'h12, 0, 0, 8'hFE));
        vecs.push_back(mk("ret_12",     2'b11, 8'h00, 8'h00, 2'd0, 0, 8'h00, 8'hFF, 8'h12, 0, 0, 8'hFF));
        vecs.push_back(mk("pop_empty",  2'b01, 8'h00, 8'h00, 2'd2, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'hFF));
        vecs.push_back(mk("ret_empty",  2'b11, 8'h00, 8'h00, 2'd0, 0, 8'h00, 8'h00, 8'h00, 0, 1, 8'hFF));
        vecs.push_back(mk("push_bf",    2'b00, 8'h3C, 8'h00, 2'd0, 1, 8'hBF, 8'h00, 8'h00, 1, 0, 8'hBF));
        vecs.push_back(mk("call_bf",    2'b10, 8'h55, 8'h66, 2'd0, 0, 8'h00, 8'h00, 8'h00, 1, 0, 8'hBF));
        vecs.push_back(mk("push_c0",    2'b00, 8'h77, 8'h00, 2'd0, 1, 8'hC0, 8'hC0, 8'h77, 0, 0, 8'hBF));
        vecs.push_back(mk("pop_bf_r2",  2'b01, 8'h00, 8'h00, 2'd2, 0, 8'h00, 8'hC0, 8'h77, 0, 0, 8'hC0));
        vecs.push_back(mk("push_11",    2'b00, 8'h11, 8'h00, 2'd0, 1, 8'hFF, 8'hFF, 8'h11, 0, 0, 8'hFE));
        vecs.push_back(mk("push_22",    2'b00, 8'h22, 8'h00, 2'd0, 0, 8'h00, 8'hFE, 8'h22, 0, 0, 8'hFD));
        vecs.push_back(mk("pop_r0_22",  2'b01, 8'h00, 8'h00, 2'd0, 0, 8'h00, 8'hFE, 8'h22, 0, 0, 8'hFE));
        vecs.push_back(mk("pop_r1_11",  2'b01, 8'h00, 8'h00, 2'd1, 0, 8'h00, 8'hFF, 8'h11, 0, 0, 8'hFF));

        rst = 1'b1;
        op_valid = 1'b0; op_code = 2'b00; op_data = 8'h00; op_target = 8'h00; op_dest = 2'd0;
        sp = 8'hFF;
        #1;
        chk("rst_op_ready", 32'(op_ready), 32'(1));
        chk("rst_outputs", 32'({done, mem_we, mem_re, stack_push, stack_pop, wb_en, pc_load, err_ovf, err_udf}), 32'(0));
        chk("rst_buses", 32'({mem_addr, mem_wdata, wb_data, pc_out}), 32'(0));
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        mon_en = 1'b1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // Reset asserted while a POP is in RD_REQ must abort without further activity.
        mon_en = 1'b0;
        load_sp(8'hFE);
        wait_ready();
        op_code = 2'b01; op_dest = 2'd2; op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        chk("abort_in_rd_req", 32'(mem_re), 32'(1));
        rst = 1'b1;
        #1;
        chk("abort_op_ready", 32'(op_ready), 32'(1));
        chk("abort_outputs", 32'({done, mem_we, mem_re, stack_push, stack_pop, wb_en, pc_load}), 32'(0));
        chk("abort_buses", 32'({mem_addr, wb_data, pc_out}), 32'(0));
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            chk("abort_quiet", 32'({done, wb_en, mem_re, mem_we, stack_pop, stack_push}), 32'(0));
        end
        chk("abort_sp_kept", 32'(sp), 32'(8'hFE));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
